mem_port_arbiter: RTL and testbench

Shares a single memory port between the pipeline's instruction-fetch requester and its data (MEM-stage) requester. It serialises the two into one outstanding transaction at a time. It registers the command onto the port, waits for command accept and response, then returns data with a one-cycle done pulse. The pipeline's hazard logic derives `stallF`/`stallM` as `req & ~done`.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch (I) and a data (D) requester, one transaction at a time.
// Ports: clk, rst (async, active-low); i_req/i_addr -> i_rdata/i_done; d_req/d_we/d_be/d_addr/d_wdata -> d_rdata/d_done;
//        m_req/m_we/m_be/m_addr/m_wdata command out, m_ack/m_rvalid/m_rdata from memory; busy = not idle.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_ack,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [DW/8-1:0]   m_be_q, m_be_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [DW-1:0]     m_wdata_q, m_wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;
  logic              grant_d;
  logic              resp;
  // owner/last encode 1 = D, 0 = I; a tie goes to whoever was not granted last
  assign grant_d = d_req & (~i_req | ~last_q);
  // a response counts only in WAIT, or in CMD together with the accept
  assign resp = m_rvalid & ((state_q == WAIT) | (state_q == CMD & m_ack));
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = resp ? m_rdata : rdata_q;
    i_done_d  = resp & ~owner_q;
    d_done_d  = resp & owner_q;
    case (state_q)
      IDLE: if (i_req | d_req) begin
        state_d   = CMD;
        m_req_d   = 1'b1;
        owner_d   = grant_d;
        last_d    = grant_d;
        m_we_d    = grant_d & d_we;
        m_be_d    = grant_d ? d_be : '1;
        m_addr_d  = grant_d ? d_addr : i_addr;
        m_wdata_d = grant_d ? d_wdata : m_wdata_q;
      end
      CMD: if (m_ack) begin
        m_req_d = 1'b0;
        state_d = m_rvalid ? DONE : WAIT;
      end
      WAIT: state_d = m_rvalid ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      busy_q    <= busy_d;
    end
  end
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of fetch/data arbitration, handshake timing and async reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        busy;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_m_be", m_be, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_rdata", i_rdata, 0);
    tick();
    tick();
    rst = 1'b1;
    i_req = 1'b1;
    i_addr = 32'hBFC0_0000;
    tick();
    chk("f_m_req1", m_req, 1);
    chk("f_m_we", m_we, 0);
    chk("f_m_be", m_be, 4'hF);
    chk("f_m_addr", m_addr, 32'hBFC0_0000);
    chk("f_busy", busy, 1);
    m_ack = 1'b1;
    tick();
    chk("f_m_req2", m_req, 0);
    m_ack = 1'b0;
    tick();
    chk("f_no_done3", i_done, 0);
    m_rvalid = 1'b1;
    m_rdata = 32'h2408_0001;
    tick();
    chk("f_i_done4", i_done, 1);
    chk("f_i_rdata", i_rdata, 32'h2408_0001);
    chk("f_d_done4", d_done, 0);
    m_rvalid = 1'b0;
    i_req = 1'b0;
    tick();
    chk("f_i_done5", i_done, 0);
    chk("f_idle", busy, 0);
    d_req = 1'b1;
    d_we = 1'b1;
    d_be = 4'h3;
    d_addr = 32'h10;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("w_m_req", m_req, 1);
    chk("w_m_we", m_we, 1);
    chk("w_m_be", m_be, 4'h3);
    chk("w_m_addr", m_addr, 32'h10);
    chk("w_m_wdata", m_wdata, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("w_hold_req", m_req, 1);
      chk("w_hold_addr", m_addr, 32'h10);
      chk("w_hold_wdata", m_wdata, 32'hDEAD_BEEF);
      chk("w_hold_be", m_be, 4'h3);
    end
    m_ack = 1'b1;
    tick();
    chk("w_req_drop", m_req, 0);
    chk("w_no_done", d_done, 0);
    m_ack = 1'b0;
    m_rvalid = 1'b1;
    m_rdata = 32'h0000_0001;
    tick();
    chk("w_d_done", d_done, 1);
    chk("w_i_done", i_done, 0);
    m_rvalid = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    tick();
    chk("w_d_done_end", d_done, 0);
    i_req = 1'b1;
    i_addr = 32'h100;
    tick();
    chk("s_m_req", m_req, 1);
    m_ack = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'hAAAA_5555;
    tick();
    chk("s_m_req_drop", m_req, 0);
    chk("s_i_done", i_done, 1);
    chk("s_i_rdata", i_rdata, 32'hAAAA_5555);
    m_ack = 1'b0;
    m_rvalid = 1'b0;
    i_req = 1'b0;
    tick();
    chk("s_i_done_end", i_done, 0);
    chk("s_idle", busy, 0);
    m_rvalid = 1'b1;
    m_rdata = 32'h1111_1111;
    tick();
    chk("sp_idle_busy", busy, 0);
    chk("sp_idle_done", i_done | d_done, 0);
    chk("sp_idle_rdata", i_rdata, 32'hAAAA_5555);
    m_rvalid = 1'b0;
    d_req = 1'b1;
    d_be = 4'hF;
    d_addr = 32'h20;
    tick();
    chk("sp_m_req", m_req, 1);
    chk("sp_m_we", m_we, 0);
    m_rvalid = 1'b1;
    m_rdata = 32'h2222_2222;
    tick();
    chk("sp_cmd_req", m_req, 1);
    chk("sp_cmd_done", d_done, 0);
    chk("sp_cmd_rdata", d_rdata, 32'hAAAA_5555);
    m_rvalid = 1'b0;
    m_ack = 1'b1;
    tick();
    chk("sp_wait", m_req, 0);
    chk("sp_wait_busy", busy, 1);
    m_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("r_m_req", m_req, 0);
    chk("r_busy", busy, 0);
    chk("r_m_addr", m_addr, 0);
    chk("r_m_be", m_be, 0);
    chk("r_m_wdata", m_wdata, 0);
    chk("r_rdata", d_rdata, 0);
    chk("r_done", i_done | d_done, 0);
    i_req = 1'b1;
    i_addr = 32'h200;
    tick();
    rst = 1'b1;
    tick();
    chk("t1_m_req", m_req, 1);
    chk("t1_grant_d", m_addr, 32'h20);
    m_ack = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'h0000_00D1;
    tick();
    chk("t1_d_done", d_done, 1);
    chk("t1_i_done", i_done, 0);
    chk("t1_rdata", d_rdata, 32'h0000_00D1);
    m_ack = 1'b0;
    m_rvalid = 1'b0;
    tick();
    tick();
    chk("t2_grant_i", m_addr, 32'h200);
    chk("t2_m_be", m_be, 4'hF);
    m_ack = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'h0000_0011;
    tick();
    chk("t2_i_done", i_done, 1);
    chk("t2_d_done", d_done, 0);
    chk("t2_rdata", i_rdata, 32'h0000_0011);
    m_ack = 1'b0;
    m_rvalid = 1'b0;
    tick();
    tick();
    chk("t3_grant_d", m_addr, 32'h20);
    m_ack = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'h0000_00D2;
    tick();
    chk("t3_d_done", d_done, 1);
    chk("t3_rdata", d_rdata, 32'h0000_00D2);
    m_ack = 1'b0;
    m_rvalid = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    chk("end_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
